// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: four-digit BCD stopwatch (0000-9999) for a seven-segment display.
// A prescaler divides clk down to a count tick while running; start_stop and lap
// act on rising edges, clear forces the block back to zero/idle.
// Handshake note: there is no valid/ready traffic here; every control input is a
// level sampled on each rising clk edge, and every output is registered or a
// 2:1 mux of registered values.
module stopwatch_bcd #(
   parameter int TICK_DIV = 500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] d0,
   output logic [3:0] d1,
   output logic [3:0] d2,
   output logic [3:0] d3,
   output logic       running,
   output logic       frozen,
   output logic       overflow,
   output logic [1:0] dbg_state
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_STOP = 2'd2;

   logic [1:0]      r_state;
   logic            r_ss_q;
   logic            r_lap_q;
   logic [PW-1:0]   r_presc;
   logic [3:0][3:0] r_cnt;
   logic [3:0][3:0] r_snap;
   logic            r_frozen;
   logic            r_overflow;

   logic            w_ss_edge;
   logic            w_lap_edge;
   logic            w_tick;
   logic [3:0][3:0] w_cnt_inc;
   logic            w_wrap;

   assign w_ss_edge  = start_stop & ~r_ss_q;
   assign w_lap_edge = lap & ~r_lap_q;
   assign w_tick     = (r_state == ST_RUN) && (r_presc == PRESC_MAX);

   // Ripple a decimal carry through the four digits; w_wrap marks 9999 -> 0000.
   always_comb begin
      logic w_carry;
      w_cnt_inc = r_cnt;
      w_carry   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (w_carry) begin
            if (r_cnt[i] == 4'd9) begin
               w_cnt_inc[i] = 4'd0;
            end else begin
               w_cnt_inc[i] = r_cnt[i] + 4'd1;
               w_carry      = 1'b0;
            end
         end
      end
      w_wrap = w_carry;
   end

   // Previous-cycle copies of the key inputs; they keep updating during clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ss_q  <= 1'b0;
         r_lap_q <= 1'b0;
      end else begin
         r_ss_q  <= start_stop;
         r_lap_q <= lap;
      end
   end

   // Run/stop state machine; clear always returns to IDLE.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_state <= ST_IDLE;
      end else if (w_ss_edge) begin
         case (r_state)
            ST_IDLE: r_state <= ST_RUN;
            ST_RUN:  r_state <= ST_STOP;
            ST_STOP: r_state <= ST_RUN;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Prescaler advances only in RUN and holds its phase across a stop.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_presc <= '0;
      end else if (r_state == ST_RUN) begin
         if (w_tick) r_presc <= '0;
         else        r_presc <= r_presc + PW'(1);
      end
   end

   // Live BCD count and the sticky wrap flag.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_cnt      <= '0;
         r_overflow <= 1'b0;
      end else if (w_tick) begin
         r_cnt <= w_cnt_inc;
         if (w_wrap) r_overflow <= 1'b1;
      end
   end

   // Lap freeze toggle; the snapshot takes the count as it was before this edge.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_frozen <= 1'b0;
         r_snap   <= '0;
      end else if (w_lap_edge) begin
         r_frozen <= ~r_frozen;
         if (!r_frozen) r_snap <= r_cnt;
      end
   end

   assign d0        = r_frozen ? r_snap[0] : r_cnt[0];
   assign d1        = r_frozen ? r_snap[1] : r_cnt[1];
   assign d2        = r_frozen ? r_snap[2] : r_cnt[2];
   assign d3        = r_frozen ? r_snap[3] : r_cnt[3];
   assign running   = (r_state == ST_RUN);
   assign frozen    = r_frozen;
   assign overflow  = r_overflow;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with TICK_DIV=4.
module tb_stopwatch_bcd;

   logic       clk = 1'b0;
   logic       reset, start_stop, clear, lap;
   logic [3:0] d0, d1, d2, d3;
   logic       running, frozen, overflow;
   logic [1:0] dbg_state;

   int checks   = 0;
   int failures = 0;
   int bad_nib  = 0;

   stopwatch_bcd #(.TICK_DIV(4)) dut (
      .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .running(running), .frozen(frozen), .overflow(overflow), .dbg_state(dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // every displayed digit must be a decimal digit at every sample
   always @(negedge clk) begin
      if (!reset && (d0 > 4'd9 || d1 > 4'd9 || d2 > 4'd9 || d3 > 4'd9)) bad_nib++;
   end

   // advance n rising edges, land 1 time unit after the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] disp();
      return {d3, d2, d1, d0};
   endfunction

   initial begin
      reset = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
      step(2);
      reset = 1'b0;

      // 1: idle after reset
      step(10);
      chk("reset_disp", 32'(disp()), 32'h0000);
      chk("reset_running", 32'(running), 32'd0);
      chk("reset_frozen", 32'(frozen), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);
      chk("reset_state", 32'(dbg_state), 32'd0);

      // 2: start and run 40 cycles
      start_stop = 1'b1; step(1); start_stop = 1'b0;
      chk("start_running", 32'(running), 32'd1);
      step(3);
      chk("before_first_tick", 32'(disp()), 32'h0000);
      step(1);
      chk("first_tick", 32'(disp()), 32'h0001);
      step(36);
      chk("run40", 32'(disp()), 32'h0010);

      // clear back to idle
      clear = 1'b1; step(1); clear = 1'b0;
      chk("clear_disp", 32'(disp()), 32'h0000);
      chk("clear_running", 32'(running), 32'd0);

      // 3: stop at 0005 with prescaler at 2, then resume
      start_stop = 1'b1; step(1); start_stop = 1'b0;
      step(21);
      chk("pre_stop_count", 32'(disp()), 32'h0005);
      start_stop = 1'b1; step(1); start_stop = 1'b0;
      chk("stop_running", 32'(running), 32'd0);
      chk("stop_state", 32'(dbg_state), 32'd2);
      step(20);
      chk("stopped_hold", 32'(disp()), 32'h0005);
      start_stop = 1'b1; step(1); start_stop = 1'b0;
      chk("resume_running", 32'(running), 32'd1);
      step(1);
      chk("resume_plus1", 32'(disp()), 32'h0005);
      step(1);
      chk("resume_plus2", 32'(disp()), 32'h0006);

      // 4: run to 9998, wrap, sticky overflow, clear
      clear = 1'b1; step(1); clear = 1'b0;
      start_stop = 1'b1; step(1); start_stop = 1'b0;
      step(39992);
      chk("count_9998", 32'(disp()), 32'h9998);
      step(4);
      chk("count_9999", 32'(disp()), 32'h9999);
      chk("no_ovf_9999", 32'(overflow), 32'd0);
      step(4);
      chk("wrap_0000", 32'(disp()), 32'h0000);
      chk("ovf_set", 32'(overflow), 32'd1);
      step(8);
      chk("after_wrap", 32'(disp()), 32'h0002);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      clear = 1'b1; step(1); clear = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);
      chk("clear2_disp", 32'(disp()), 32'h0000);

      // 5: lap at 0023 on a tick edge
      start_stop = 1'b1; step(1); start_stop = 1'b0;
      step(95);
      chk("pre_lap", 32'(disp()), 32'h0023);
      lap = 1'b1; step(1); lap = 1'b0;
      chk("lap_frozen", 32'(frozen), 32'd1);
      chk("lap_snap", 32'(disp()), 32'h0023);
      step(12);
      chk("lap_hold", 32'(disp()), 32'h0023);
      lap = 1'b1; step(1); lap = 1'b0;
      chk("unlap_frozen", 32'(frozen), 32'd0);
      chk("unlap_live", 32'(disp()), 32'h0027);

      // 6: clear and start_stop together while stopped
      start_stop = 1'b1; step(1); start_stop = 1'b0;
      chk("stop5_state", 32'(dbg_state), 32'd2);
      step(1);
      clear = 1'b1; start_stop = 1'b1; step(1); clear = 1'b0;
      chk("clr_ss_state", 32'(dbg_state), 32'd0);
      chk("clr_ss_disp", 32'(disp()), 32'h0000);
      chk("clr_ss_running", 32'(running), 32'd0);
      step(3);
      chk("held_after_clear", 32'(dbg_state), 32'd0);
      start_stop = 1'b0; step(1);
      start_stop = 1'b1; step(1); start_stop = 1'b0;
      chk("restart_running", 32'(running), 32'd1);
      step(2);
      start_stop = 1'b1; step(1);
      chk("held_toggle", 32'(running), 32'd0);
      step(9);
      chk("held_once", 32'(dbg_state), 32'd2);
      start_stop = 1'b0;

      // reset mid-run leaves no pending tick
      step(1);
      start_stop = 1'b1; step(1); start_stop = 1'b0;
      step(3);
      reset = 1'b1; step(1); reset = 1'b0;
      chk("midrun_reset_running", 32'(running), 32'd0);
      step(4);
      chk("midrun_reset_disp", 32'(disp()), 32'h0000);

      chk("nibble_range", 32'(bad_nib), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
